// File: rtl/max10flash_arbiter.sv
// Two-port round-robin read arbiter in front of the MAX10 on-chip flash
// Avalon-MM data port. One burst is owned at a time: the winner's command is
// latched, issued to the flash, and the returned beats go back to the owner.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate among pending requesters
// CMD     | latched command driven to flash, waiting for acceptance
// DATA    | burst accepted, steering beats to owner until count hits 0
module max10flash_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  s0_addr,
    input  logic               s0_read,
    input  logic [BURST_W-1:0] s0_burstcount,
    output logic               s0_waitrequest,
    output logic [DATA_W-1:0]  s0_readdata,
    output logic               s0_readdatavalid,
    input  logic [ADDR_W-1:0]  s1_addr,
    input  logic               s1_read,
    input  logic [BURST_W-1:0] s1_burstcount,
    output logic               s1_waitrequest,
    output logic [DATA_W-1:0]  s1_readdata,
    output logic               s1_readdatavalid,
    output logic [ADDR_W-1:0]  avmm_data_addr,
    output logic               avmm_data_read,
    output logic [BURST_W-1:0] avmm_data_burstcount,
    input  logic               avmm_data_waitrequest,
    input  logic [DATA_W-1:0]  avmm_data_readdata,
    input  logic               avmm_data_readdatavalid,
    output logic [1:0]         grant,
    output logic               err_spurious
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [BURST_W-1:0] ONE_BEAT = {{(BURST_W-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [BURST_W-1:0] cmd_burst;
    logic [BURST_W-1:0] beat_cnt;
    logic               last_grant;   // 1: port 1 owned the previous burst

    logic               pick1;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BURST_W-1:0] sel_burst;

    // Round-robin winner: port 1 wins alone, or on a tie when port 0 went last
    always_comb begin
        pick1     = s1_read && (!s0_read || !last_grant);
        sel_addr  = pick1 ? s1_addr : s0_addr;
        sel_burst = pick1 ? s1_burstcount : s0_burstcount;
        if (sel_burst == '0) begin
            sel_burst = ONE_BEAT;
        end
    end

    // Burst sequencer: latch winner, issue command, count returned beats
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            cmd_addr   <= '0;
            cmd_burst  <= '0;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s0_read || s1_read) begin
                        cmd_addr  <= sel_addr;
                        cmd_burst <= sel_burst;
                        grant     <= pick1 ? 2'b10 : 2'b01;
                        state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!avmm_data_waitrequest) begin
                        beat_cnt   <= cmd_burst;
                        last_grant <= grant[1];
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (avmm_data_readdatavalid) begin
                        beat_cnt <= beat_cnt - ONE_BEAT;
                        if (beat_cnt == ONE_BEAT) begin
                            grant <= 2'b00;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for flash beats arriving when no burst is outstanding
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_spurious <= 1'b0;
        end else if (avmm_data_readdatavalid && (state != ST_DATA)) begin
            err_spurious <= 1'b1;
        end
    end

    // Flash command and per-port handshake/data steering
    always_comb begin
        avmm_data_read       = (state == ST_CMD);
        avmm_data_addr       = cmd_addr;
        avmm_data_burstcount = cmd_burst;
        s0_waitrequest       = !((state == ST_CMD) && grant[0] && !avmm_data_waitrequest);
        s1_waitrequest       = !((state == ST_CMD) && grant[1] && !avmm_data_waitrequest);
        s0_readdatavalid     = avmm_data_readdatavalid && (state == ST_DATA) && grant[0];
        s1_readdatavalid     = avmm_data_readdatavalid && (state == ST_DATA) && grant[1];
        s0_readdata          = avmm_data_readdata;
        s1_readdata          = avmm_data_readdata;
    end

endmodule

// File: tb/tb_max10flash_arbiter.sv
// Bench for max10flash_arbiter: flash model, two requesters and a per-port
// scoreboard of expected beat data.
module tb_max10flash_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] s0_addr = '0, s1_addr = '0;
    logic        s0_read = 1'b0, s1_read = 1'b0;
    logic [3:0]  s0_burstcount = '0, s1_burstcount = '0;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [15:0] avmm_data_addr;
    logic        avmm_data_read;
    logic [3:0]  avmm_data_burstcount;
    logic        avmm_data_waitrequest = 1'b1;
    logic [31:0] avmm_data_readdata = '0;
    logic        avmm_data_readdatavalid = 1'b0;
    logic [1:0]  grant;
    logic        err_spurious;

    int checks = 0;
    int errors = 0;

    max10flash_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .s0_addr(s0_addr), .s0_read(s0_read), .s0_burstcount(s0_burstcount),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_addr(s1_addr), .s1_read(s1_read), .s1_burstcount(s1_burstcount),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
        .avmm_data_burstcount(avmm_data_burstcount),
        .avmm_data_waitrequest(avmm_data_waitrequest),
        .avmm_data_readdata(avmm_data_readdata),
        .avmm_data_readdatavalid(avmm_data_readdatavalid),
        .grant(grant), .err_spurious(err_spurious)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] beat_data(input logic [15:0] a, input int i);
        logic [31:0] iv;
        iv = i;
        beat_data = 32'hDEADBEEF ^ {a ^ 16'h0010, 8'h00, iv[7:0]};
    endfunction

    // ---------------- flash model (acts on falling edge) ----------------
    int          fl_stall = 0;
    int          stall_cnt = 0;
    int          pend = 0;
    int          m_idx = 0;
    logic [15:0] m_addr = '0, acc_addr = '0;
    logic [3:0]  acc_bc = '0;
    bit          rd_prev = 0, wr_prev = 1, inj = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            pend = 0; m_idx = 0; stall_cnt = 0;
            rd_prev = 0; wr_prev = 1;
            avmm_data_readdatavalid = 1'b0;
            avmm_data_waitrequest = 1'b1;
        end else begin
            if (rd_prev && !wr_prev) begin
                pend = acc_bc; m_addr = acc_addr; m_idx = 0;
            end
            if (pend > 0) begin
                avmm_data_readdatavalid = 1'b1;
                avmm_data_readdata = beat_data(m_addr, m_idx);
                m_idx++; pend--;
            end else if (inj) begin
                avmm_data_readdatavalid = 1'b1;
                avmm_data_readdata = 32'h0BAD0BAD;
                inj = 0;
            end else begin
                avmm_data_readdatavalid = 1'b0;
            end
            if (avmm_data_read) begin
                if (stall_cnt < fl_stall) begin
                    avmm_data_waitrequest = 1'b1; stall_cnt++;
                end else begin
                    avmm_data_waitrequest = 1'b0; stall_cnt = 0;
                    acc_addr = avmm_data_addr; acc_bc = avmm_data_burstcount;
                end
            end else begin
                avmm_data_waitrequest = 1'b1;
            end
            rd_prev = avmm_data_read;
            wr_prev = avmm_data_waitrequest;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] q0[$], q1[$];
    int          cnt0 = 0, cnt1 = 0;
    logic [1:0]  grant_log[$];
    logic [1:0]  prev_grant = 2'b00;

    always @(negedge clock) begin
        logic [31:0] exp_d;
        #1;
        if (s0_readdatavalid) begin
            cnt0++; checks++;
            if (q0.size() == 0) begin
                errors++; $display("FAIL s0_beat: unexpected beat data=%h, none expected", s0_readdata);
            end else begin
                exp_d = q0.pop_front();
                if (s0_readdata !== exp_d) begin
                    errors++; $display("FAIL s0_data: got %h expected %h", s0_readdata, exp_d);
                end
            end
        end
        if (s1_readdatavalid) begin
            cnt1++; checks++;
            if (q1.size() == 0) begin
                errors++; $display("FAIL s1_beat: unexpected beat data=%h, none expected", s1_readdata);
            end else begin
                exp_d = q1.pop_front();
                if (s1_readdata !== exp_d) begin
                    errors++; $display("FAIL s1_data: got %h expected %h", s1_readdata, exp_d);
                end
            end
        end
        if (grant !== prev_grant && grant !== 2'b00) grant_log.push_back(grant);
        prev_grant = grant;
    end

    // ---------------- requester helpers ----------------
    task automatic issue(input int port, input logic [15:0] a, input logic [3:0] b,
                         output int stalls, output logic rd_c1, output logic [3:0] bc_c1);
        int  n;
        bit  done;
        logic wr;
        @(negedge clock);
        if (port == 0) begin
            s0_addr = a; s0_burstcount = b; s0_read = 1'b1;
        end else begin
            s1_addr = a; s1_burstcount = b; s1_read = 1'b1;
        end
        n = (b == 0) ? 1 : b;
        for (int i = 0; i < n; i++) begin
            if (port == 0) q0.push_back(beat_data(a, i));
            else           q1.push_back(beat_data(a, i));
        end
        stalls = 0; rd_c1 = 1'b0; bc_c1 = '0; done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clock); #1;
            if (k == 0) begin
                rd_c1 = avmm_data_read; bc_c1 = avmm_data_burstcount;
            end
            wr = (port == 0) ? s0_waitrequest : s1_waitrequest;
            if (!wr) done = 1;
            else stalls++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: port %0d waitrequest still 1, required 0", port);
        end
        @(posedge clock); #1;
        if (port == 0) s0_read = 1'b0;
        else           s1_read = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clock); #2;
            if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: q0=%0d q1=%0d grant=%b, required empty/00", q0.size(), q1.size(), grant);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (grant !== 2'b00 || avmm_data_read !== 1'b0 || avmm_data_addr !== 16'h0 ||
            avmm_data_burstcount !== 4'h0 || s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b1 ||
            s0_readdatavalid !== 1'b0 || s1_readdatavalid !== 1'b0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL %s: grant=%b rd=%b addr=%h bc=%h wr0=%b wr1=%b v0=%b v1=%b err=%b, required 00 0 0000 0 1 1 0 0 0",
                     tag, grant, avmm_data_read, avmm_data_addr, avmm_data_burstcount,
                     s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid, err_spurious);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        check_reset_outputs("reset_state");
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock); #2;
        check_reset_outputs("after_release");
    endtask

    task automatic test_single_read();
        int st; logic rc1; logic [3:0] bc;
        cnt0 = 0; cnt1 = 0; fl_stall = 0;
        issue(0, 16'h0010, 4'd1, st, rc1, bc);
        checks++;
        if (rc1 !== 1'b1) begin errors++; $display("FAIL single_read_c1: avmm_data_read=%b required 1", rc1); end
        checks++;
        if (st != 0) begin errors++; $display("FAIL single_wr_c1: s0 stall cycles=%0d required 0", st); end
        wait_drain();
        checks++;
        if (cnt0 != 1 || cnt1 != 0) begin errors++; $display("FAIL single_beats: s0=%0d s1=%0d required 1 0", cnt0, cnt1); end
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL single_grant: got %b required 00", grant); end
    endtask

    task automatic test_stalled_burst();
        int st; logic rc1; logic [3:0] bc;
        cnt0 = 0; cnt1 = 0; fl_stall = 3;
        issue(1, 16'h1230, 4'd8, st, rc1, bc);
        checks++;
        if (st != 3) begin errors++; $display("FAIL stall_cycles: s1 waitrequest high %0d cycles, required 3", st); end
        @(negedge clock); #2;
        checks++;
        if (s1_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_wr_after: s1_waitrequest=%b required 1", s1_waitrequest); end
        wait_drain();
        checks++;
        if (cnt1 != 8 || cnt0 != 0) begin errors++; $display("FAIL stall_beats: s1=%0d s0=%0d required 8 0", cnt1, cnt0); end
        fl_stall = 0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g[4];
        cnt0 = 0; cnt1 = 0; fl_stall = 0;
        grant_log.delete();
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        fork
            begin
                int st; logic rc1; logic [3:0] bc;
                issue(0, 16'h0100, 4'd2, st, rc1, bc);
                issue(0, 16'h0104, 4'd2, st, rc1, bc);
            end
            begin
                int st; logic rc1; logic [3:0] bc;
                issue(1, 16'h2000, 4'd2, st, rc1, bc);
                issue(1, 16'h2004, 4'd2, st, rc1, bc);
            end
        join
        wait_drain();
        checks++;
        if (grant_log.size() != 4) begin
            errors++; $display("FAIL rr_count: %0d grants seen, required 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant_log[i] !== exp_g[i]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %b required %b", i, grant_log[i], exp_g[i]);
                end
            end
        end
        checks++;
        if (cnt0 != 4 || cnt1 != 4) begin errors++; $display("FAIL rr_beats: s0=%0d s1=%0d required 4 4", cnt0, cnt1); end
    endtask

    task automatic test_burst_zero();
        int st; logic rc1; logic [3:0] bc;
        cnt0 = 0; cnt1 = 0;
        issue(0, 16'h0444, 4'd0, st, rc1, bc);
        checks++;
        if (bc !== 4'd1) begin errors++; $display("FAIL burst0_bc: avmm_data_burstcount=%0d required 1", bc); end
        wait_drain();
        checks++;
        if (cnt0 != 1) begin errors++; $display("FAIL burst0_beats: s0=%0d required 1", cnt0); end
        checks++;
        if (err_spurious !== 1'b0) begin errors++; $display("FAIL err_clean: err_spurious=%b required 0", err_spurious); end
    endtask

    task automatic test_spurious();
        cnt0 = 0; cnt1 = 0;
        @(negedge clock); #2;
        inj = 1;
        @(negedge clock); #2;
        checks++;
        if (!avmm_data_readdatavalid || s0_readdatavalid || s1_readdatavalid) begin
            errors++; $display("FAIL spur_drop: flash_v=%b v0=%b v1=%b required 1 0 0",
                                 avmm_data_readdatavalid, s0_readdatavalid, s1_readdatavalid);
        end
        @(negedge clock); #2;
        checks++;
        if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_set: err_spurious=%b required 1", err_spurious); end
        repeat (5) @(negedge clock);
        #2;
        checks++;
        if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky: err_spurious=%b required 1", err_spurious); end
    endtask

    task automatic test_reset_mid_burst();
        int st; logic rc1; logic [3:0] bc;
        bit seen;
        cnt0 = 0; cnt1 = 0; seen = 0;
        issue(0, 16'h0200, 4'd8, st, rc1, bc);
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock); #2;
            if (cnt0 == 3) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_beats: saw %0d beats, required 3", cnt0); end
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        q0.delete(); q1.delete();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        cnt0 = 0; cnt1 = 0;
        issue(1, 16'h0300, 4'd1, st, rc1, bc);
        wait_drain();
        checks++;
        if (cnt1 != 1 || cnt0 != 0) begin errors++; $display("FAIL post_reset_beats: s1=%0d s0=%0d required 1 0", cnt1, cnt0); end
        checks++;
        if (err_spurious !== 1'b0) begin errors++; $display("FAIL post_reset_err: err_spurious=%b required 0", err_spurious); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_stalled_burst();
        test_back_to_back();
        test_burst_zero();
        test_spurious();
        test_reset_mid_burst();
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/max10flash_arbiter.md
# max10flash_arbiter

Two-port round-robin arbiter that shares the single burst-capable Avalon-MM read port of the MAX10 on-chip flash (UFM/CFM data interface) between two read-only requesters (e.g. CPU instruction fetch on port 0, boot/DMA loader on port 1). It sits between the requesters and the flash IP and grants one burst at a time. It latches the winning command, forwards it to the flash, and steers the returned beats back to the owner until the burst completes.

## Interface
Parameters:
- ADDR_W, 16, word address width (flash `avmm_data_addr`)
- DATA_W, 32, read data width
- BURST_W, 4, burstcount width

Ports:
- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- s0_addr / s1_addr  in  ADDR_W  requester word address
- s0_read / s1_read  in  1  requester read request
- s0_burstcount / s1_burstcount  in  BURST_W  requested beats
- s0_waitrequest / s1_waitrequest  out  1  command not yet accepted
- s0_readdata / s1_readdata  out  DATA_W  returned data (both driven from flash readdata)
- s0_readdatavalid / s1_readdatavalid  out  1  beat valid for this requester
- avmm_data_addr  out  ADDR_W  to flash
- avmm_data_read  out  1  to flash
- avmm_data_burstcount  out  BURST_W  to flash
- avmm_data_waitrequest  in  1  from flash
- avmm_data_readdata  in  DATA_W  from flash
- avmm_data_readdatavalid  in  1  from flash
- grant  out  2  one-hot current owner, 00 when idle
- err_spurious  out  1  sticky: flash readdatavalid seen outside DATA state

## Operation
- FSM states: IDLE, CMD, DATA.
- IDLE: if any sN_read=1, pick the winner, latch its addr and burstcount into cmd registers, set grant, and go to CMD.
  - Burstcount 0 is coerced to 1 at latch time.
  - Arbitration: a single requester wins outright. With both requesting, the winner is the port not granted last. last_grant resets to port 1, so port 0 wins the first tie.
- CMD: avmm_data_read=1 with the latched addr and burstcount. When avmm_data_waitrequest=0, the command is accepted. The beat counter loads the latched burstcount, last_grant updates, and the FSM goes to DATA.
- DATA: each avmm_data_readdatavalid decrements the beat counter and asserts the owner's sN_readdatavalid. On the final beat (counter==1 with valid), go to IDLE and clear grant.
- sN_waitrequest = NOT(state==CMD AND grant==N AND avmm_data_waitrequest==0). It is high at all other times, including in IDLE.
- sN_readdatavalid = avmm_data_readdatavalid AND state==DATA AND grant==N. readdata passes straight through to both ports.
- A requester that drops read while stalled is a protocol violation. The latched command is still executed and its beats are delivered.
- avmm_data_readdatavalid in IDLE or CMD is dropped and sets err_spurious. Only reset clears err_spurious.
- Only one burst is outstanding at a time; there is no pipelining of commands.

## Timing
- Reset values: state=IDLE, grant=00, avmm_data_read=0, avmm_data_addr=0, avmm_data_burstcount=0, sN_waitrequest=1, sN_readdatavalid=0, err_spurious=0, beat counter=0, last_grant=port 1.
- Request sampled in IDLE at cycle 0. avmm_data_read is registered high from cycle 1.
- With zero flash stall, the requester sees waitrequest=0 in cycle 1, and the command is accepted that cycle.
- First beat is accepted no earlier than cycle 2. sN_readdatavalid has zero added latency relative to flash readdatavalid.
- There is one IDLE bubble cycle after the last beat before the next grant.
- The next command therefore issues at least 2 cycles after the last beat.
- Reset mid-burst: all state returns to reset values immediately (asynchronously). Flash beats arriving after reset release set err_spurious, because the flash shares reset_n and should produce none.

## Test plan
- Single read, port 0: addr=0x0010, burst=1, flash waitrequest low.
  - avmm_data_read high in cycle 1; s0_waitrequest low in cycle 1.
  - One s0_readdatavalid with flash data 0xDEADBEEF; grant returns to 00.
- Burst of 8 on port 1 with 3 stall cycles of flash waitrequest.
  - s1_waitrequest stays high for 3 cycles, then low for 1 cycle.
  - Exactly 8 s1_readdatavalid pulses; s0_readdatavalid never asserts.
- Both ports request continuously, burst=2 each.
  - Grants alternate 01, 10, 01, 10.
  - Port 0 wins first; each burst delivers 2 beats to its owner only.
- Burstcount 0 on port 0: avmm_data_burstcount=1 and one beat is delivered.
- Flash readdatavalid injected in IDLE: no sN_readdatavalid, and err_spurious goes to 1 and stays 1 until reset.
- reset_n asserted after beat 3 of an 8-beat burst:
  - outputs return to reset values immediately;
  - after release, a new port 1 burst=1 read completes normally.
